// File: rtl/dyt_rf_pkg.sv
// ---------------------------------------------------------------------------
// dyt_rf_pkg
// Shared definitions for the 16-entry register file and the logic that
// drives its single write port.
//   RF_ADDR_WIDTH / RF_DATA_WIDTH / RF_NUM_WORDS : register file geometry
//   rf_wr_t    : one write-port beat {en, addr, data}
//   wb_grant_e : which producer owns the write port in a given cycle
// ---------------------------------------------------------------------------
package dyt_rf_pkg;

  localparam int RF_ADDR_WIDTH = 4;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_NUM_WORDS  = 16;

  typedef struct packed {
    logic                     en;
    logic [RF_ADDR_WIDTH-1:0] addr;
    logic [RF_DATA_WIDTH-1:0] data;
  } rf_wr_t;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_ALU    = 2'd1,
    GNT_FIFO   = 2'd2,
    GNT_BYPASS = 2'd3
  } wb_grant_e;

endpackage

// File: rtl/dyt_wb_fifo.sv
// ---------------------------------------------------------------------------
// dyt_wb_fifo
// Small FIFO holding load results that lost write-port arbitration. Every
// entry carries a kill bit: once set, the entry is still popped in order but
// must not be written to the register file.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   push_i/push_addr_i/
//   push_data_i/push_kill_i     enqueue one load (optionally already killed)
//   pop_i                       dequeue the head entry
//   kill_en_i/kill_addr_i       set kill bit of every live entry at kill_addr_i
//   chk_addr_i/chk_pending_o    a live, non-killed entry targets chk_addr_i
//   full_o/empty_o              occupancy flags
//   head_addr_o/head_data_o/
//   head_kill_o                 contents of the head entry
// ---------------------------------------------------------------------------
module dyt_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          push_kill_i,
  input  logic          pop_i,
  input  logic          kill_en_i,
  input  logic [AW-1:0] kill_addr_i,
  input  logic [AW-1:0] chk_addr_i,
  output logic          chk_pending_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o,
  output logic          head_kill_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [DEPTH-1:0] pend;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];

  // Pointers are PW bits wide, so wrap modulo DEPTH comes for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic wr_here;
      logic rd_here;
      logic kill_hit;

      assign wr_here  = push_i && (wr_ptr_q == PW'(gi));
      assign rd_here  = pop_i  && (rd_ptr_q == PW'(gi));
      assign kill_hit = kill_en_i && valid_q[gi] && (addr_q[gi] == kill_addr_i);

      // A slot is never written and read in the same cycle: a push needs
      // the FIFO not full, so the write slot is always free.
      assign valid_d[gi] = wr_here ? 1'b1 : (rd_here ? 1'b0 : valid_q[gi]);
      assign kill_d[gi]  = wr_here ? push_kill_i : (kill_q[gi] | kill_hit);

      assign pend[gi] = valid_q[gi] && !kill_q[gi] && (addr_q[gi] == chk_addr_i);
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      kill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      kill_q   <= kill_d;
    end
  end

  // Payload storage needs no reset: valid_q gates every use of it.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign full_o        = (count_q == CW'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign head_addr_o   = addr_q[rd_ptr_q];
  assign head_data_o   = data_q[rd_ptr_q];
  assign head_kill_o   = kill_q[rd_ptr_q];
  assign chk_pending_o = (chk_addr_i != '0) && (|pend);

endmodule

// File: rtl/dyt_rf_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// dyt_rf_writeback_arbiter
// Drives the register file write port from the ALU (no back-pressure) and
// the load unit (valid/ready). Loads that lose arbitration wait in
// dyt_wb_fifo. An ALU write kills any older buffered load to the same
// register so the younger ALU value is never overwritten.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   alu_valid_i/alu_addr_i/alu_data_i   ALU result, always accepted
//   ld_valid_i/ld_ready_o/
//   ld_addr_i/ld_data_i                 load result handshake
//   chk_addr_i/chk_pending_o            decode hazard query (combinational)
//   w_en_o/w_addr_o/w_data_o            registered register file write port
// ---------------------------------------------------------------------------
module dyt_rf_writeback_arbiter
  import dyt_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alu_valid_i,
  input  logic [ADDR_WIDTH-1:0] alu_addr_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic [DATA_WIDTH-1:0] ld_data_i,
  input  logic [ADDR_WIDTH-1:0] chk_addr_i,
  output logic                  chk_pending_o,
  output logic                  w_en_o,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  output logic [DATA_WIDTH-1:0] w_data_o
);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_kill;

  logic      alu_win;
  logic      ld_acc;
  logic      fifo_pop;
  logic      fifo_push;
  logic      push_kill;
  wb_grant_e grant;

  rf_wr_t wr_q, wr_d;

  // Ready depends only on current occupancy; a same-cycle pop does not
  // open a slot early.
  assign ld_ready_o = rst_ni && !fifo_full;

  // A write to x0 is architecturally a no-op, so it does not claim the port.
  assign alu_win = alu_valid_i && (alu_addr_i != '0);
  assign ld_acc  = ld_valid_i && ld_ready_o;

  always_comb begin
    if (alu_win) begin
      grant = GNT_ALU;
    end else if (!fifo_empty) begin
      grant = GNT_FIFO;
    end else if (ld_acc) begin
      grant = GNT_BYPASS;
    end else begin
      grant = GNT_NONE;
    end
  end

  assign fifo_pop  = (grant == GNT_FIFO);
  assign fifo_push = ld_acc && (grant != GNT_BYPASS);
  // The ALU result is younger than a load accepted in the same cycle.
  assign push_kill = alu_win && (ld_addr_i == alu_addr_i);

  dyt_wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (fifo_push),
    .push_addr_i   (ld_addr_i),
    .push_data_i   (ld_data_i),
    .push_kill_i   (push_kill),
    .pop_i         (fifo_pop),
    .kill_en_i     (alu_win),
    .kill_addr_i   (alu_addr_i),
    .chk_addr_i    (chk_addr_i),
    .chk_pending_o (chk_pending_o),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .head_kill_o   (head_kill)
  );

  // Address/data hold their last value when idle; only en matters then.
  always_comb begin
    wr_d      = wr_q;
    wr_d.en   = 1'b0;
    unique case (grant)
      GNT_ALU: begin
        wr_d.en   = 1'b1;
        wr_d.addr = alu_addr_i;
        wr_d.data = alu_data_i;
      end
      GNT_FIFO: begin
        // Killed or x0 entries still consume their slot, silently.
        wr_d.en   = (head_addr != '0) && !head_kill;
        wr_d.addr = head_addr;
        wr_d.data = head_data;
      end
      GNT_BYPASS: begin
        wr_d.en   = (ld_addr_i != '0);
        wr_d.addr = ld_addr_i;
        wr_d.data = ld_data_i;
      end
      default: begin
        wr_d.en   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
    end else begin
      wr_q <= wr_d;
    end
  end

  assign w_en_o   = wr_q.en;
  assign w_addr_o = wr_q.addr;
  assign w_data_o = wr_q.data;

endmodule

// File: tb/tb_dyt_rf_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dyt_rf_writeback_arbiter
// Directed stimulus with a cycle-accurate reference model: each clock edge
// the model predicts the write-port beat, pushes it to a scoreboard queue
// tagged with the cycle it must appear, and a negedge monitor pops and
// compares every observed write.
// ---------------------------------------------------------------------------
module tb_dyt_rf_writeback_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  chk_addr;
  logic        chk_pending;
  logic        w_en;
  logic [3:0]  w_addr;
  logic [31:0] w_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dyt_rf_writeback_arbiter #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .alu_valid_i   (alu_valid),
    .alu_addr_i    (alu_addr),
    .alu_data_i    (alu_data),
    .ld_valid_i    (ld_valid),
    .ld_ready_o    (ld_ready),
    .ld_addr_i     (ld_addr),
    .ld_data_i     (ld_data),
    .chk_addr_i    (chk_addr),
    .chk_pending_o (chk_pending),
    .w_en_o        (w_en),
    .w_addr_o      (w_addr),
    .w_data_o      (w_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    bit          kill;
  } ment_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  ment_t       mq[$];
  exp_t        exp_q[$];
  int          cyc_cnt = 0;
  logic [31:0] rf_model [16];

  bit    m_ready, m_alu_w, m_acc, m_bypass;
  ment_t m_e;

  always @(posedge clk) begin
    cyc_cnt++;
    if (!rst_n) begin
      mq.delete();
    end else begin
      m_ready  = (mq.size() < DEPTH);
      m_alu_w  = alu_valid && (alu_addr != 4'd0);
      m_acc    = ld_valid && m_ready;
      m_bypass = 1'b0;
      if (m_alu_w) begin
        foreach (mq[i]) if (mq[i].addr == alu_addr) mq[i].kill = 1'b1;
        exp_q.push_back('{alu_addr, alu_data, cyc_cnt});
      end else if (mq.size() > 0) begin
        m_e = mq.pop_front();
        if (m_e.addr != 4'd0 && !m_e.kill) exp_q.push_back('{m_e.addr, m_e.data, cyc_cnt});
      end else if (m_acc) begin
        m_bypass = 1'b1;
        if (ld_addr != 4'd0) exp_q.push_back('{ld_addr, ld_data, cyc_cnt});
      end
      if (m_acc && !m_bypass)
        mq.push_back('{ld_addr, ld_data, m_alu_w && (ld_addr == alu_addr)});
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due < cyc_cnt) begin
      check("wr_missing_due", 64'(exp_q[0].due), 64'(cyc_cnt));
      void'(exp_q.pop_front());
    end
    if (w_en === 1'b1) begin
      $display("t=%0t write x%0d = %08h", $time, w_addr, w_data);
      rf_model[w_addr] = w_data;
      if (exp_q.size() == 0) begin
        check("wr_unexpected_en", 64'(w_en), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(w_addr), 64'(mon_e.addr));
        check("wr_data", 64'(w_data), 64'(mon_e.data));
        check("wr_cycle", 64'(cyc_cnt), 64'(mon_e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  int lds [3] = '{8, 9, 10};
  int li;
  bit accepted;

  initial begin
    foreach (rf_model[i]) rf_model[i] = '0;
    rst_n = 1'b0; alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid = 1'b1; ld_addr = 4'd9; ld_data = 32'h99; chk_addr = '0;

    // Reset
    repeat (3) cyc();
    check("rst_ld_ready", 64'(ld_ready), 64'(0));
    check("rst_w_en",     64'(w_en),     64'(0));
    check("rst_w_addr",   64'(w_addr),   64'(0));
    check("rst_w_data",   64'(w_data),   64'(0));
    ld_valid = 1'b0;
    rst_n    = 1'b1;
    cyc();
    check("rel_ld_ready", 64'(ld_ready), 64'(1));

    // ALU alone
    alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 32'hDEADBEEF;
    cyc();
    check("alu_w_en",   64'(w_en),   64'(1));
    check("alu_w_addr", 64'(w_addr), 64'(5));
    check("alu_w_data", 64'(w_data), 64'hDEADBEEF);
    alu_addr = 4'd0; alu_data = 32'h1234;
    cyc();
    check("alu_x0_w_en", 64'(w_en), 64'(0));
    idle();
    cyc();

    // Collision: ALU x3 and load x7 together, FIFO empty
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h11;
    ld_valid  = 1'b1; ld_addr  = 4'd7; ld_data  = 32'h22;
    chk_addr  = 4'd7;
    #1;
    check("col_ld_ready",   64'(ld_ready),    64'(1));
    check("col_pend_before", 64'(chk_pending), 64'(0));
    cyc();
    check("col_w1_addr", 64'(w_addr), 64'(3));
    check("col_w1_data", 64'(w_data), 64'h11);
    idle();
    #1;
    check("col_pend_buffered", 64'(chk_pending), 64'(1));
    cyc();
    check("col_w2_en",   64'(w_en),   64'(1));
    check("col_w2_addr", 64'(w_addr), 64'(7));
    check("col_w2_data", 64'(w_data), 64'h22);
    check("col_pend_after", 64'(chk_pending), 64'(0));
    cyc();

    // Back-pressure: ALU x1..x4 while loads stream x8, x9, x10
    li = 0;
    for (int c = 0; c < 12 && (c < 4 || li < 3); c++) begin
      alu_valid = (c < 4);
      alu_addr  = 4'(c + 1);
      alu_data  = 32'h100 + 32'(c);
      ld_valid  = (li < 3);
      ld_addr   = 4'(lds[li < 3 ? li : 2]);
      ld_data   = 32'h200 + 32'(li);
      #1;
      if (c == 2) check("bp_full_ready", 64'(ld_ready), 64'(0));
      if (c == 4) check("bp_pop_no_raise", 64'(ld_ready), 64'(0));
      accepted = ld_valid && ld_ready;
      cyc();
      if (accepted) li++;
    end
    check("bp_loads_accepted", 64'(li), 64'(3));
    idle();
    repeat (3) cyc();
    check("bp_rf_x10", 64'(rf_model[10]), 64'h202);

    // Kill: buffered load x6 overtaken by ALU x6
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h1;
    ld_valid  = 1'b1; ld_addr  = 4'd6; ld_data  = 32'hAAAA;
    chk_addr  = 4'd6;
    cyc();
    ld_valid = 1'b0;
    alu_addr = 4'd6; alu_data = 32'hBBBB;
    #1;
    check("kill_pend_before", 64'(chk_pending), 64'(1));
    cyc();
    check("kill_alu_data", 64'(w_data), 64'hBBBB);
    alu_valid = 1'b0;
    #1;
    check("kill_pend_after", 64'(chk_pending), 64'(0));
    cyc();
    check("kill_pop_w_en", 64'(w_en), 64'(0));
    cyc();
    check("kill_rf_x6", 64'(rf_model[6]), 64'hBBBB);

    // Mid-operation reset with two buffered loads
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h31;
    ld_valid  = 1'b1; ld_addr  = 4'd11; ld_data = 32'h41;
    cyc();
    alu_addr = 4'd2; alu_data = 32'h32;
    ld_addr  = 4'd12; ld_data = 32'h42;
    cyc();
    alu_addr = 4'd3; alu_data = 32'h33;
    ld_valid = 1'b0;
    chk_addr = 4'd11;
    #1;
    check("mrst_pend_before", 64'(chk_pending), 64'(1));
    cyc();
    idle();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_w_en",     64'(w_en),        64'(0));
    check("mrst_pend_11",  64'(chk_pending), 64'(0));
    check("mrst_ld_ready", 64'(ld_ready),    64'(0));
    chk_addr = 4'd12;
    #1;
    check("mrst_pend_12",  64'(chk_pending), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) cyc();
    check("mrst_no_late_write", 64'(w_en), 64'(0));
    check("mrst_rf_x11", 64'(rf_model[11]), 64'(0));

    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dyt_rf_writeback_arbiter.md
Name: dyt_rf_writeback_arbiter

Overview:
Drives the single write port of the 16-entry register file (w_en/w_addr/w_data) from two producers: the ALU, which cannot stall, and the load unit, which uses a valid/ready handshake. Load results that lose arbitration are held in a small FIFO. A combinational scoreboard output lets decode stall on registers with a buffered load still outstanding. The block sits between execute/memory and the register file.

Parameters:
ADDR_WIDTH, 4, register address width; fixed to match the register file (16 registers, x0 hard-wired to zero).
DATA_WIDTH, 32, register data width.
DEPTH, 2, load FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
alu_valid  in  1  ALU result valid this cycle; always accepted, no back-pressure.
alu_addr  in  ADDR_WIDTH  ALU destination register.
alu_data  in  DATA_WIDTH  ALU result.
ld_valid  in  1  load result valid.
ld_ready  out  1  load result accepted when ld_valid and ld_ready are both high.
ld_addr  in  ADDR_WIDTH  load destination register.
ld_data  in  DATA_WIDTH  load data.
chk_addr  in  ADDR_WIDTH  register queried by decode.
chk_pending  out  1  a live buffered load targets chk_addr.
w_en  out  1  register file write enable.
w_addr  out  ADDR_WIDTH  register file write address.
w_data  out  DATA_WIDTH  register file write data.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: w_en=0, w_addr=0, w_data=0. The FIFO is empty and all kill bits are clear.
- ld_ready = rst && !fifo_full. It is 0 while reset is asserted.
- w_en, w_addr and w_data are registered. A winning source appears on the write port exactly 1 cycle after it is presented.
- Per-cycle grant, in priority order:
  1. ALU write: alu_valid && alu_addr!=0.
  2. FIFO head, if the FIFO is non-empty.
  3. Bypass of the incoming load: FIFO empty and ld_valid && ld_ready.
- An accepted load that is not bypassed is pushed to the FIFO. Pop and push may occur in the same cycle. At full, a pop in the same cycle does not raise ld_ready; ready depends only on current occupancy.
- A popped FIFO entry drives w_en=1 only if its addr!=0 and its kill bit is clear. Otherwise it is consumed with w_en=0 for that slot.
- An ALU write to x0 is treated as no ALU write. Lower priorities may use that cycle.
- A load to x0 is accepted normally and never produces w_en=1.
- Ordering rule: an ALU result is younger than every load accepted in the same or an earlier cycle.
  - On an ALU grant to address A, set the kill bit of every FIFO entry whose addr==A.
  - If an incoming load accepted in that cycle also targets A, it is pushed already killed.
  - The ALU value is never overwritten by an older load.
- chk_pending = (chk_addr!=0) && any valid, non-killed FIFO entry with addr==chk_addr. It is combinational and does not include the load in flight on the output register.
- Reset mid-operation: buffered loads are discarded and w_en drops immediately. The load unit must re-issue anything it needs.
- No overflow is possible: a push happens only when ld_ready=1.
- Occupancy counter is $clog2(DEPTH)+1 bits. Read and write pointers wrap modulo DEPTH.

Decomposition:
- Shared package dyt_rf_pkg holds:
  - RF_ADDR_WIDTH=4, RF_DATA_WIDTH=32, RF_NUM_WORDS=16.
  - Typedef rf_wr_t = {en, addr, data}, shared with the register file write port.
- One sub-module, dyt_wb_fifo: a DEPTH-entry FIFO with a per-entry kill bit, a kill-by-address input and a pending-lookup port. The arbiter glue stays in the top module.

Test Plan:
- Reset: hold rst=0 with ld_valid=1 -> ld_ready=0, w_en=0. Release rst -> ld_ready=1 on the next cycle.
- ALU alone: alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF -> next cycle w_en=1, w_addr=5, w_data=0xDEADBEEF. With alu_addr=0 -> w_en=0.
- Collision: same cycle ALU (x3, 0x11) and load (x7, 0x22), FIFO empty -> cycle+1 writes x3/0x11, cycle+2 writes x7/0x22. chk_addr=7 reads pending=1 for exactly one cycle.
- Back-pressure: ALU writes x1..x4 on consecutive cycles while loads stream to x8, x9, x10 -> FIFO fills to 2, ld_ready=0 on the third load. After the ALU stops, the loads drain as x8, x9, x10 in order with no loss.
- Kill: load (x6, 0xAAAA) buffered, then ALU (x6, 0xBBBB) -> x6 written 0xBBBB. The FIFO pop produces w_en=0, chk_pending(x6)=0 after the ALU grant, and the final x6 is 0xBBBB.
- Mid-operation reset: two loads buffered, assert rst=0 for 1 cycle -> w_en=0, FIFO empty, chk_pending=0, and no buffered write appears afterward.
